// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module riscv_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       DivOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             sel_rem_q, sel_rem_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             signed_op, a_neg, b_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
    logic [WIDTH:0]   rem_shift, trial;

    assign signed_op = ~DivOp[0];
    assign a_neg     = signed_op & SrcA[WIDTH-1];
    assign b_neg     = signed_op & SrcB[WIDTH-1];
    assign mag_a     = a_neg ? (~SrcA + 1'b1) : SrcA;
    assign mag_b     = b_neg ? (~SrcB + 1'b1) : SrcB;
    assign div_zero  = (SrcB == '0);
    assign sgn_ovf   = signed_op && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);

    // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign quo_fix   = qsign_q ? (~dvd_q + 1'b1) : dvd_q;
    assign rem_fix   = rsign_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d   = state_q;
        sel_rem_d = sel_rem_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start && !Flush) begin
                    sel_rem_d = DivOp[1];
                    dvd_d     = mag_a;
                    dvs_d     = mag_b;
                    qsign_d   = a_neg ^ b_neg;
                    rsign_d   = a_neg;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    if (div_zero) begin
                        result_d = DivOp[1] ? SrcA : '1;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = DivOp[1] ? '0 : SrcA;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = sel_rem_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_rem_q <= 1'b0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_rem_q <= sel_rem_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign Busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign Done   = (state_q == S_DONE);
    assign Result = result_q;

endmodule
